// File: rtl/quad_encoder_counter.sv
// One rotary-encoder channel: synchronises and debounces the A/B pins, decodes
// quadrature steps and keeps a WIDTH-bit level that feeds one PWM duty input.
module quad_encoder_counter #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 255,
   parameter int STEP            = 1,
   parameter bit SATURATE        = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enc_a,
   input  logic             enc_b,
   output logic [WIDTH-1:0] value,
   output logic             inc,
   output logic             dec,
   output logic             err
);

   typedef enum logic {INIT, RUN} state_t;

   localparam logic [15:0]      DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
   localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] MAX_V   = '1;

   state_t           state;
   state_t           state_next;
   logic [1:0]       init_cnt;
   logic             init_done;

   // Pin pairs are packed as {a, b} so they read directly as quadrature codes.
   logic [1:0]       sync1;
   logic [1:0]       sync2;
   logic [1:0]       stable;
   logic [1:0]       prev;
   logic [15:0]      db_cnt [2];

   logic             step_up;
   logic             step_down;
   logic             illegal;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] value_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= INIT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      init_done  = 1'b0;
      case (state)
         INIT: begin
            if (init_cnt == 2'd2) begin
               init_done  = 1'b1;
               state_next = RUN;
            end
         end
         RUN: state_next = RUN;
         default: state_next = INIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         init_cnt <= 2'd0;
         sync1    <= 2'b00;
         sync2    <= 2'b00;
      end else begin
         sync1 <= {enc_a, enc_b};
         sync2 <= sync1;
         if (state == INIT) begin
            init_cnt <= init_cnt + 2'd1;
         end
      end
   end

   // Leaving INIT seeds stable and prev straight from the synchroniser so that
   // pins already high at reset release never produce a count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable <= 2'b00;
         prev   <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            db_cnt[i] <= 16'd0;
         end
      end else if (init_done) begin
         stable <= sync2;
         prev   <= sync2;
         for (int i = 0; i < 2; i++) begin
            db_cnt[i] <= 16'd0;
         end
      end else if (state == RUN) begin
         prev <= stable;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == stable[i]) begin
               db_cnt[i] <= 16'd0;
            end else if (db_cnt[i] == DB_LAST) begin
               stable[i] <= sync2[i];
               db_cnt[i] <= 16'd0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 16'd1;
            end
         end
      end
   end

   always_comb begin
      step_up   = 1'b0;
      step_down = 1'b0;
      illegal   = 1'b0;
      if (state == RUN && stable != prev) begin
         case ({prev, stable})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_up   = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_down = 1'b1;
            default:                                illegal   = 1'b1;
         endcase
      end
   end

   // The carry out of the widened sum and the borrow test decide clamping.
   always_comb begin
      sum        = {1'b0, value} + {1'b0, STEP_V};
      value_next = value;
      if (step_up) begin
         value_next = (SATURATE && sum[WIDTH]) ? MAX_V : sum[WIDTH-1:0];
      end else if (step_down) begin
         value_next = (SATURATE && (value < STEP_V)) ? '0 : value - STEP_V;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value <= '0;
         inc   <= 1'b0;
         dec   <= 1'b0;
         err   <= 1'b0;
      end else begin
         value <= value_next;
         inc   <= step_up;
         dec   <= step_down;
         err   <= illegal;
      end
   end

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Bench for quad_encoder_counter: four instances (wrap/clamp, STEP 1/8) share
// the encoder pins and are checked every cycle against a window-based model.
module tb_quad_encoder_counter;

   localparam int DB   = 4;
   localparam int HIST = 4096;

   logic       clk = 1'b0;
   logic       reset;
   logic       enc_a;
   logic       enc_b;
   logic [7:0] val    [4];
   logic       inc_o  [4];
   logic       dec_o  [4];
   logic       err_o  [4];

   int step_p [4] = '{1, 1, 8, 8};
   int sat_p  [4] = '{0, 1, 0, 1};

   int checks = 0;
   int errors = 0;

   int inc_seen [4];
   int dec_seen [4];
   int err_seen [4];

   logic [1:0] raw_hist [HIST];
   logic [1:0] deb_hist [HIST];
   int         edge_n;
   int         exp_value [4];
   logic       exp_inc;
   logic       exp_dec;
   logic       exp_err;

   logic [1:0] gray [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
   int         ph;

   always #5 clk = ~clk;

   quad_encoder_counter #(.WIDTH(8), .DEBOUNCE_CYCLES(DB), .STEP(1), .SATURATE(1'b0)) u_wrap1 (
      .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
      .value(val[0]), .inc(inc_o[0]), .dec(dec_o[0]), .err(err_o[0]));
   quad_encoder_counter #(.WIDTH(8), .DEBOUNCE_CYCLES(DB), .STEP(1), .SATURATE(1'b1)) u_sat1 (
      .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
      .value(val[1]), .inc(inc_o[1]), .dec(dec_o[1]), .err(err_o[1]));
   quad_encoder_counter #(.WIDTH(8), .DEBOUNCE_CYCLES(DB), .STEP(8), .SATURATE(1'b0)) u_wrap8 (
      .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
      .value(val[2]), .inc(inc_o[2]), .dec(dec_o[2]), .err(err_o[2]));
   quad_encoder_counter #(.WIDTH(8), .DEBOUNCE_CYCLES(DB), .STEP(8), .SATURATE(1'b1)) u_sat8 (
      .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
      .value(val[3]), .inc(inc_o[3]), .dec(dec_o[3]), .err(err_o[3]));

   // A pin's debounced level is the value of the latest run of DB identical
   // samples; samples reach the debouncer two edges late through the synchroniser.
   function automatic logic deb_bit(input int e, input int b);
      logic same;
      for (int j = e - 2; j >= DB + 1; j--) begin
         same = 1'b1;
         for (int k = 1; k < DB; k++) begin
            if (raw_hist[j-k][b] != raw_hist[j][b]) same = 1'b0;
         end
         if (same) return raw_hist[j][b];
      end
      return raw_hist[1][b];
   endfunction

   function automatic int gray_pos(input logic [1:0] g);
      case (g)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   // Behavioural model: edge count since release, debounced history, and a
   // quadrature position difference turned into plain integer arithmetic.
   always @(posedge clk or posedge reset) begin
      int d;
      int v;
      if (reset) begin
         edge_n  = 0;
         exp_inc = 1'b0;
         exp_dec = 1'b0;
         exp_err = 1'b0;
         for (int i = 0; i < 4; i++) exp_value[i] = 0;
      end else begin
         if (edge_n < HIST - 1) edge_n++;
         raw_hist[edge_n] = {enc_a, enc_b};
         exp_inc = 1'b0;
         exp_dec = 1'b0;
         exp_err = 1'b0;
         if (edge_n >= 3) deb_hist[edge_n] = {deb_bit(edge_n, 1), deb_bit(edge_n, 0)};
         if (edge_n >= 5) begin
            d = (gray_pos(deb_hist[edge_n-1]) - gray_pos(deb_hist[edge_n-2]) + 4) % 4;
            exp_inc = (d == 1);
            exp_dec = (d == 3);
            exp_err = (d == 2);
            for (int i = 0; i < 4; i++) begin
               v = exp_value[i];
               if (exp_inc) v = v + step_p[i];
               if (exp_dec) v = v - step_p[i];
               if (sat_p[i] != 0) begin
                  if (v > 255) v = 255;
                  if (v < 0) v = 0;
               end else begin
                  v = (v + 256) % 256;
               end
               exp_value[i] = v;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Per-cycle comparison plus pulse counters, sampled on the falling edge.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("value[%0d]", i), int'(val[i]), exp_value[i]);
         checkOutput($sformatf("inc[%0d]", i), int'(inc_o[i]), int'(exp_inc));
         checkOutput($sformatf("dec[%0d]", i), int'(dec_o[i]), int'(exp_dec));
         checkOutput($sformatf("err[%0d]", i), int'(err_o[i]), int'(exp_err));
         if (!reset) begin
            inc_seen[i] += int'(inc_o[i]);
            dec_seen[i] += int'(dec_o[i]);
            err_seen[i] += int'(err_o[i]);
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic clear_counters();
      for (int i = 0; i < 4; i++) begin
         inc_seen[i] = 0;
         dec_seen[i] = 0;
         err_seen[i] = 0;
      end
   endtask

   task automatic applyStimulus(input logic a, input logic b, input int hold);
      enc_a = a;
      enc_b = b;
      wait_cycles(hold);
   endtask

   task automatic do_reset(input logic a, input logic b);
      enc_a = a;
      enc_b = b;
      reset = 1'b1;
      wait_cycles(3);
      reset = 1'b0;
      clear_counters();
   endtask

   task automatic step_cw(input int hold);
      ph = (ph + 1) % 4;
      applyStimulus(gray[ph][1], gray[ph][0], hold);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      enc_a = 1'b1;
      enc_b = 1'b1;
      clear_counters();
      #1;
      checkOutput("reset value", int'(val[0]), 0);
      checkOutput("reset inc", int'(inc_o[0]), 0);

      // Pins high at release: INIT must absorb them without a count.
      do_reset(1'b1, 1'b1);
      wait_cycles(50);
      checkOutput("pins high value", int'(val[0]), 0);
      checkOutput("pins high pulses", inc_seen[0] + dec_seen[0] + err_seen[0], 0);

      // First clockwise quarter-step with exact latency, then the full cycle.
      do_reset(1'b0, 1'b0);
      wait_cycles(10);
      enc_a = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      checkOutput("inc before k+6", int'(inc_o[0]), 0);
      @(negedge clk);
      checkOutput("inc at k+6", int'(inc_o[0]), 1);
      checkOutput("value at k+6", int'(val[0]), 1);
      @(negedge clk);
      checkOutput("inc after k+6", int'(inc_o[0]), 0);
      @(posedge clk);
      #2;
      ph = 1;
      step_cw(10);
      step_cw(10);
      step_cw(10);
      checkOutput("cw value step1", int'(val[0]), 4);
      checkOutput("cw value step8", int'(val[2]), 32);
      checkOutput("cw inc count", inc_seen[0], 4);
      checkOutput("cw dec count", dec_seen[0], 0);

      // Short glitch rejected, longer pulse counted both ways.
      clear_counters();
      applyStimulus(1'b1, 1'b0, 3);
      applyStimulus(1'b0, 1'b0, 10);
      checkOutput("glitch inc count", inc_seen[0], 0);
      applyStimulus(1'b1, 1'b0, 5);
      applyStimulus(1'b0, 1'b0, 12);
      checkOutput("pulse inc count", inc_seen[0], 1);
      checkOutput("pulse dec count", dec_seen[0], 1);
      checkOutput("pulse value", int'(val[0]), 4);

      // One counter-clockwise step from zero: wrap versus clamp.
      do_reset(1'b0, 1'b0);
      wait_cycles(10);
      applyStimulus(1'b0, 1'b1, 10);
      checkOutput("ccw wrap1", int'(val[0]), 255);
      checkOutput("ccw sat1", int'(val[1]), 0);
      checkOutput("ccw wrap8", int'(val[2]), 248);
      checkOutput("ccw sat8", int'(val[3]), 0);
      checkOutput("ccw sat dec count", dec_seen[3], 1);

      // Climb to the top boundary with STEP=8.
      do_reset(1'b0, 1'b0);
      wait_cycles(10);
      ph = 0;
      repeat (31) step_cw(8);
      checkOutput("climb sat8", int'(val[3]), 248);
      checkOutput("climb wrap8", int'(val[2]), 248);
      checkOutput("climb wrap1", int'(val[0]), 31);
      step_cw(8);
      checkOutput("top sat8", int'(val[3]), 255);
      checkOutput("top wrap8", int'(val[2]), 0);
      step_cw(8);
      checkOutput("clamped sat8", int'(val[3]), 255);
      checkOutput("clamped inc count", inc_seen[3], 33);
      checkOutput("post wrap8", int'(val[2]), 8);

      // Both pins flip together: error pulse, no count.
      clear_counters();
      applyStimulus(1'b0, 1'b1, 10);
      checkOutput("err count", err_seen[0], 1);
      checkOutput("err no count", inc_seen[0] + dec_seen[0], 0);
      checkOutput("err value sat8", int'(val[3]), 255);
      checkOutput("err value wrap1", int'(val[0]), 33);

      // Reset in the middle of a debounce: immediate clear, no count afterwards.
      applyStimulus(1'b1, 1'b1, 2);
      reset = 1'b1;
      #1;
      checkOutput("async reset wrap1", int'(val[0]), 0);
      checkOutput("async reset sat8", int'(val[3]), 0);
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;
      clear_counters();
      wait_cycles(30);
      checkOutput("post reset value", int'(val[0]), 0);
      checkOutput("post reset pulses", inc_seen[0] + dec_seen[0] + err_seen[0], 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
